mem_responder: RTL and testbench

Word-organised memory responder that serves load/store requests from the multicycle CPU over a valid/ready request channel and a valid/ready response channel, with a programmable number of wait states. It replaces the zero-latency combinational memory as the far end of the CPU memory interface, so that stall and handshake paths in the CPU control unit are exercised. Storage remains loadable by `$readmemh` from the bench at time zero.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_array.sv | 36 +++
 rtl/mem_responder.sv | 108 ++++++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: FSM states, lane count and field widths.
package mem_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam int unsigned NumLanes = 4;
   localparam int unsigned ErrW     = 1;
   localparam int unsigned CntW     = 4;

   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the CPU (master) and the memory responder (slave).
interface mem_responder_if
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic [NumLanes-1:0] req_be;
   logic [DATA_W-1:0]   req_wdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/mem_array.sv
// Word storage with synchronous byte-enabled write and registered read; contents have no reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 32,
   localparam int unsigned IdxW  = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic                re_i,
   input  logic [IdxW-1:0]     idx_i,
   input  logic [NumLanes-1:0] be_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < int'(NumLanes); i++) begin
            if (be_i[i]) begin
               mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with LATENCY wait states between accept and response.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_responder_if.slave bus
);

   localparam int unsigned       IdxW   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [ErrW-1:0]     err_q, err_d;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [NumLanes-1:0] be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                commit;
   logic                addr_err;
   logic                wr_en;
   logic                rd_en;
   logic [DATA_W-1:0]   arr_rdata;

   assign addr_err = misaligned(addr_q[1:0]) || ((addr_q >> 2) >= DepthA);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               state_d = StWait;
               cnt_d   = CntW'(LATENCY);
            end
         end
         StWait: begin
            // Memory access happens on the edge that leaves WAIT, so results are registered.
            if (cnt_q == '0) begin
               state_d = StResp;
               commit  = 1'b1;
               err_d   = ErrW'(addr_err);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
               err_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StIdle && bus.req_valid) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr;
         be_q    <= bus.req_be;
         wdata_q <= bus.req_wdata;
      end
   end

   // Gate with rst_n so a store caught by reset on its commit edge never lands.
   assign wr_en = commit && we_q && !addr_err && rst_n;
   assign rd_en = commit && !we_q && !addr_err;

   mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) array (
      .clk_i   (clk),
      .we_i    (wr_en),
      .re_i    (rd_en),
      .idx_i   (addr_q[IdxW+1:2]),
      .be_i    (be_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_err   = err_q[0];
   assign bus.rsp_rdata = (state_q == StResp && !we_q && !err_q[0]) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized checks of mem_responder against a word-array reference model.
module tb_mem_responder;

   localparam int unsigned Depth = 256;
   localparam int unsigned LatA  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_responder_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
   mem_responder_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

   mem_responder #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .DEPTH   (Depth),
      .LATENCY (LatA)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   mem_responder #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .DEPTH   (Depth),
      .LATENCY (0)
   ) dut_l0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   // Shared request drive; sel picks which responder sees req_valid and is observed.
   logic        sel = 1'b0;
   logic        v_s = 1'b0;
   logic        we_s = 1'b0;
   logic [31:0] addr_s = '0;
   logic [3:0]  be_s = '0;
   logic [31:0] wd_s = '0;
   logic        rr_s = 1'b0;

   assign a_if.req_valid = v_s & ~sel;
   assign b_if.req_valid = v_s & sel;
   assign a_if.req_we    = we_s;
   assign b_if.req_we    = we_s;
   assign a_if.req_addr  = addr_s;
   assign b_if.req_addr  = addr_s;
   assign a_if.req_be    = be_s;
   assign b_if.req_be    = be_s;
   assign a_if.req_wdata = wd_s;
   assign b_if.req_wdata = wd_s;
   assign a_if.rsp_ready = rr_s;
   assign b_if.rsp_ready = rr_s;

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   assign o_req_ready = sel ? b_if.req_ready : a_if.req_ready;
   assign o_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;
   assign o_rsp_err   = sel ? b_if.rsp_err   : a_if.rsp_err;
   assign o_rsp_rdata = sel ? b_if.rsp_rdata : a_if.rsp_rdata;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mdl [2][Depth];
   logic [31:0] last_rdata;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input int d, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic e, output logic [31:0] r);
      int idx;
      e = (addr % 4 != 0) || (addr / 4 >= Depth);
      r = '0;
      if (!e) begin
         idx = int'(addr / 4);
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
         end else begin
            r = mdl[d][idx];
         end
      end
   endtask

   task automatic txn(input logic b, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input int hold);
      logic        e;
      logic [31:0] r;
      int          lat;
      int          exp_lat;
      exp_lat = b ? 1 : int'(LatA) + 1;
      model(b ? 1 : 0, we, addr, be, wd, e, r);
      @(negedge clk);
      sel = b;
      #1;
      chk(32'(o_req_ready), 32'd1, "idle_req_ready");
      v_s = 1'b1; we_s = we; addr_s = addr; be_s = be; wd_s = wd;
      rr_s = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      // Request fields are free to change once accepted.
      v_s = 1'b0; we_s = 1'($urandom); addr_s = $urandom; be_s = 4'($urandom); wd_s = $urandom;
      lat = 0;
      while (o_rsp_valid !== 1'b1 && lat < 64) begin
         chk(32'(o_req_ready), 32'd0, "busy_req_ready");
         lat++;
         @(negedge clk);
      end
      chk(32'(lat), 32'(exp_lat), "latency");
      if (lat >= 64) return;
      for (int i = 0; i < hold; i++) begin
         chk(32'(o_rsp_valid), 32'd1, "hold_valid");
         chk(o_rsp_rdata, r, "hold_rdata");
         chk(32'(o_req_ready), 32'd0, "hold_req_ready");
         // Pending store must not be taken before the response handshake.
         v_s = 1'b1; we_s = 1'b1; addr_s = 32'($urandom_range(0, 15)) << 2; be_s = 4'hF;
         @(negedge clk);
      end
      rr_s = 1'b1;
      #1;
      chk(32'(o_rsp_valid), 32'd1, "rsp_valid");
      chk(o_rsp_rdata, r, "rsp_rdata");
      chk(32'(o_rsp_err), 32'(e), "rsp_err");
      last_rdata = o_rsp_rdata;
      @(posedge clk);
      @(negedge clk);
      v_s = 1'b0; rr_s = 1'b0;
      #1;
      chk(32'(o_rsp_valid), 32'd0, "post_valid");
      chk(32'(o_req_ready), 32'd1, "post_req_ready");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      int unsigned pick;
      for (int d = 0; d < 2; d++) for (int w = 0; w < int'(Depth); w++) mdl[d][w] = '0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(32'(a_if.rsp_valid), 32'd0, "reset_valid");
      chk(32'(a_if.rsp_err), 32'd0, "reset_err");
      chk(a_if.rsp_rdata, 32'd0, "reset_rdata");
      chk(32'(a_if.req_ready), 32'd1, "reset_req_ready");
      rst_n = 1'b1;

      txn(0, 1, 32'h4, 4'hF, 32'h8C010010, 0);
      txn(0, 0, 32'h4, 4'h0, 32'h0, 0);
      chk(last_rdata, 32'h8C010010, "load_word1");

      txn(0, 1, 32'h8, 4'hF, 32'h11223344, 0);
      txn(0, 1, 32'h8, 4'b0101, 32'hDEADBEEF, 0);
      txn(0, 0, 32'h8, 4'hF, 32'h0, 0);
      chk(last_rdata, 32'h11AD33EF, "byte_merge");

      txn(0, 0, 32'h6, 4'hF, 32'h0, 0);
      txn(0, 0, 32'h400, 4'hF, 32'h0, 0);
      txn(0, 1, 32'h402, 4'hF, 32'hFFFFFFFF, 1);
      txn(0, 0, 32'h4, 4'hF, 32'h0, 0);
      txn(0, 0, 32'h8, 4'hF, 32'h0, 5);

      // Store aborted by reset during WAIT must leave the word untouched.
      txn(0, 1, 32'h10, 4'hF, 32'h55AA55AA, 0);
      @(negedge clk);
      sel = 1'b0; v_s = 1'b1; we_s = 1'b1; addr_s = 32'h10; be_s = 4'hF; wd_s = 32'hBAD0BAD0;
      rr_s = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v_s = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; rr_s = 1'b0;
      chk(32'(a_if.rsp_valid), 32'd0, "midreset_valid");
      chk(32'(a_if.rsp_err), 32'd0, "midreset_err");
      chk(a_if.rsp_rdata, 32'd0, "midreset_rdata");
      chk(32'(a_if.req_ready), 32'd1, "midreset_req_ready");
      txn(0, 0, 32'h10, 4'hF, 32'h0, 0);
      chk(last_rdata, 32'h55AA55AA, "aborted_store");

      txn(1, 1, 32'h20, 4'hF, 32'hCAFEF00D, 0);
      txn(1, 0, 32'h20, 4'h0, 32'h0, 2);
      chk(last_rdata, 32'hCAFEF00D, "lat0_load");
      txn(1, 0, 32'h21, 4'h0, 32'h0, 0);

      for (int k = 0; k < 16; k++) txn(0, 1, 32'(k * 4), 4'hF, $urandom, 0);
      for (int k = 0; k < 40; k++) begin
         pick = $urandom_range(0, 7);
         a = 32'($urandom_range(0, 15)) << 2;
         if (pick == 0) a = a | 32'($urandom_range(1, 3));
         else if (pick == 1) a = 32'(256 + $urandom_range(0, 1000)) << 2;
         txn(0, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
             int'($urandom_range(0, 3)));
      end
      for (int k = 0; k < 16; k++) txn(0, 0, 32'(k * 4), 4'h0, 32'h0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
